// File: rtl/snn_pkg.sv
// Shared packet layout, constants and FSM state type for the spike map collector.
// Drain packets are built here so every producer agrees on the field layout.
package snn_pkg;

    localparam int PKT_W    = 64;
    localparam int ROW_BITS = 21;

    localparam int DEST_HI = 63;
    localparam int DEST_LO = 60;
    localparam int SRC_HI  = 59;
    localparam int SRC_LO  = 56;
    localparam int TYPE_HI = 55;
    localparam int TYPE_LO = 54;
    localparam int TS_HI   = 35;
    localparam int TS_LO   = 32;
    localparam int ROW_HI  = 31;
    localparam int ROW_LO  = 27;
    localparam int X_HI    = 9;
    localparam int X_LO    = 5;
    localparam int Y_HI    = 4;
    localparam int Y_LO    = 0;

    localparam logic [1:0] OUT_SPIKE_TYPE = 2'b11;
    localparam logic [9:0] DONE_ADDR      = 10'h3FF;
    localparam logic [4:0] END_ROW        = 5'h1F;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_DRAIN,
        ST_END,
        ST_CLEAR
    } collector_state_t;

    function automatic logic [PKT_W-1:0] make_drain_pkt(
        input logic [3:0]          dest,
        input logic [3:0]          src,
        input logic [3:0]          ts,
        input logic [4:0]          row,
        input logic [ROW_BITS-1:0] bits
    );
        logic [PKT_W-1:0] p;
        p                   = '0;
        p[DEST_HI:DEST_LO]  = dest;
        p[SRC_HI:SRC_LO]    = src;
        p[TYPE_HI:TYPE_LO]  = OUT_SPIKE_TYPE;
        p[TS_HI:TS_LO]      = ts;
        p[ROW_HI:ROW_LO]    = row;
        p[ROW_BITS-1:0]     = bits;
        return p;
    endfunction

endpackage

// File: rtl/spike_packet_decode.sv
// Combinational classification of an incoming adder packet into spike / done / malformed.
module spike_packet_decode
    import snn_pkg::*;
#(
    parameter logic [3:0] MY_ADDR = 4'b1010,
    parameter int         MAP_X   = 21,
    parameter int         MAP_Y   = 21
) (
    input  logic [PKT_W-1:0] pkt,
    output logic             is_spike,
    output logic             is_done,
    output logic             is_bad,
    output logic [4:0]       x,
    output logic [4:0]       y
);

    logic hdr_ok;
    logic coord_ok;
    logic unused_bits;

    // Source and padding fields carry no meaning for classification.
    assign unused_bits = ^{pkt[SRC_HI:SRC_LO], pkt[TYPE_LO-1:X_HI+1]};

    always_comb begin
        x        = pkt[X_HI:X_LO];
        y        = pkt[Y_HI:Y_LO];
        hdr_ok   = (pkt[DEST_HI:DEST_LO] == MY_ADDR) && (pkt[TYPE_HI:TYPE_LO] == OUT_SPIKE_TYPE);
        is_done  = hdr_ok && (pkt[X_HI:Y_LO] == DONE_ADDR);
        coord_ok = (int'(x) < MAP_X) && (int'(y) < MAP_Y);
        is_spike = hdr_ok && !is_done && coord_ok;
        is_bad   = !is_done && !is_spike;
    end

endmodule

// File: rtl/spike_map_collector.sv
// Collects one spike map per timestep from the adders and drains it row by row to memory.
// Optional build macro SPIKE_SKIP_EMPTY_ROWS_EN: drain skips all-zero rows (END always sent).
module spike_map_collector
    import snn_pkg::*;
#(
    parameter logic [3:0] MY_ADDR       = 4'b1010,
    parameter logic [3:0] MEM_ADDR      = 4'b0000,
    parameter int         NUM_ADDERS    = 7,
    parameter int         MAP_X         = 21,
    parameter int         MAP_Y         = 21,
    parameter int         NUM_TIMESTEPS = 10,
    parameter int         WIDTH         = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       timestep,
    output logic             err
);

    localparam int DCW = $clog2(NUM_ADDERS + 1);
`ifdef SPIKE_SKIP_EMPTY_ROWS_EN
    localparam bit SKIP_EMPTY = 1'b1;
`else
    localparam bit SKIP_EMPTY = 1'b0;
`endif

    collector_state_t state_q, state_d;
    logic [MAP_Y-1:0] map_q [MAP_X];
    logic [MAP_Y-1:0] map_d [MAP_X];
    logic [4:0]       row_q, row_d, row_next;
    logic [DCW-1:0]   done_cnt_q, done_cnt_d;
    logic [3:0]       ts_q, ts_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             accept;
    logic             is_spike, is_done, is_bad;
    logic [4:0]       sx, sy;

    spike_packet_decode #(
        .MY_ADDR (MY_ADDR),
        .MAP_X   (MAP_X),
        .MAP_Y   (MAP_Y)
    ) u_decode (
        .pkt      (in_data),
        .is_spike (is_spike),
        .is_done  (is_done),
        .is_bad   (is_bad),
        .x        (sx),
        .y        (sy)
    );

    assign accept   = in_valid && in_ready_q;
    assign row_next = row_q + 5'd1;

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        row_d       = row_q;
        done_cnt_d  = done_cnt_q;
        ts_d        = ts_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (is_bad) begin
                        err_d = 1'b1;
                    end else if (is_spike) begin
                        map_d[sx][sy] = 1'b1;
                    end else if (is_done) begin
                        if (done_cnt_q == DCW'(NUM_ADDERS - 1)) begin
                            done_cnt_d  = '0;
                            row_d       = '0;
                            state_d     = ST_DRAIN;
                            out_valid_d = !SKIP_EMPTY || (|map_q[0]);
                            out_data_d  = make_drain_pkt(MEM_ADDR, MY_ADDR, ts_q, 5'd0, map_q[0]);
                        end else begin
                            done_cnt_d = done_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // An invisible (skipped) row advances without waiting for a handshake.
                if (!out_valid_q || out_ready) begin
                    if (row_q == 5'(MAP_X - 1)) begin
                        state_d     = ST_END;
                        out_valid_d = 1'b1;
                        out_data_d  = make_drain_pkt(MEM_ADDR, MY_ADDR, ts_q, END_ROW, '0);
                    end else begin
                        row_d       = row_next;
                        out_valid_d = !SKIP_EMPTY || (|map_q[row_next]);
                        out_data_d  = make_drain_pkt(MEM_ADDR, MY_ADDR, ts_q, row_next, map_q[row_next]);
                    end
                end
            end
            ST_END: begin
                if (out_ready) begin
                    state_d     = ST_CLEAR;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                end
            end
            ST_CLEAR: begin
                for (int i = 0; i < MAP_X; i++) begin
                    map_d[i] = '0;
                end
                ts_d    = (ts_q == 4'(NUM_TIMESTEPS - 1)) ? 4'd0 : ts_q + 4'd1;
                row_d   = '0;
                state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase

        in_ready_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            row_q       <= '0;
            done_cnt_q  <= '0;
            ts_q        <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < MAP_X; i++) begin
                map_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            done_cnt_q  <= done_cnt_d;
            ts_q        <= ts_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < MAP_X; i++) begin
                map_q[i] <= map_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign timestep  = ts_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spike_map_collector.sv
// Scoreboard bench for spike_map_collector: stimulus queues expected drain packets,
// a monitor pops and compares on every output handshake.
module tb_spike_map_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [3:0]  timestep;
    logic        err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb [$];
    logic [20:0] model_map [21];

    always #5 clk = ~clk;

    spike_map_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .timestep  (timestep),
        .err       (err)
    );

    function automatic logic [63:0] exp_pkt(input logic [3:0] ts, input logic [4:0] row, input logic [20:0] d);
        return {4'h0, 4'hA, 2'b11, 18'd0, ts, row, 6'd0, d};
    endfunction

    function automatic logic [63:0] pkt_in(input logic [1:0] ty, input logic [4:0] x, input logic [4:0] y);
        return {4'hA, 4'h1, ty, 44'd0, x, y};
    endfunction

    localparam logic [63:0] DONE_PKT = {4'hA, 4'h2, 2'b11, 44'd0, 10'h3FF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic send(input logic [63:0] p);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = p;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for packet %h", p);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_dones(input int n);
        for (int i = 0; i < n; i++) send(DONE_PKT);
    endtask

    // Queue the full drain (rows then END) for the hand-set model map, then clear the model.
    task automatic push_drain(input logic [3:0] ts);
        for (int r = 0; r < 21; r++) begin
`ifdef SPIKE_SKIP_EMPTY_ROWS_EN
            if (model_map[r] != 21'd0)
`endif
            sb.push_back(exp_pkt(ts, 5'(r), model_map[r]));
        end
        sb.push_back(exp_pkt(ts, 5'h1F, 21'd0));
        for (int r = 0; r < 21; r++) model_map[r] = '0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(sb.size() == 0 && in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic empty_timestep(input logic [3:0] ts);
        send_dones(6);
        push_drain(ts);
        send(DONE_PKT);
        wait_drain("drain_empty_ts");
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h, expected no packet", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_pkt", out_data, e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 21; r++) model_map[r] = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_timestep", 64'(timestep), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_rise", 64'(in_ready), 64'd1);

        // Timestep 0: spikes with a duplicate
        send(pkt_in(2'b11, 5'd3, 5'd7));
        send(pkt_in(2'b11, 5'd3, 5'd7));
        send(pkt_in(2'b11, 5'd20, 5'd20));
        send_dones(6);
        model_map[3]  = 21'h000080;
        model_map[20] = 21'h100000;
        push_drain(4'd0);
        send(DONE_PKT);
        check("in_ready_drop", 64'(in_ready), 64'd0);
`ifndef SPIKE_SKIP_EMPTY_ROWS_EN
        check("first_out_valid", 64'(out_valid), 64'd1);
`endif
        wait_drain("drain_ts0");
        check("ts_after_0", 64'(timestep), 64'd1);
        check("err_clean", 64'(err), 64'd0);

        // Timestep 1: malformed packets are dropped and do not count as dones
        send(pkt_in(2'b10, 5'd1, 5'd1));
        send(pkt_in(2'b11, 5'd21, 5'd0));
        check("err_set", 64'(err), 64'd1);
        send_dones(6);
        check("not_closed_after_6", 64'(in_ready), 64'd1);
        push_drain(4'd1);
        send(DONE_PKT);
        wait_drain("drain_ts1");
        check("ts_after_1", 64'(timestep), 64'd2);
        check("err_sticky", 64'(err), 64'd1);

        // Timestep 2: backpressure on row 0
        send(pkt_in(2'b11, 5'd0, 5'd2));
        send_dones(6);
        model_map[0] = 21'h000004;
        push_drain(4'd2);
        out_ready = 1'b0;
        send(DONE_PKT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", out_data, exp_pkt(4'd2, 5'd0, 21'h000004));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
`ifndef SPIKE_SKIP_EMPTY_ROWS_EN
        check("row1_after_hs", out_data, exp_pkt(4'd2, 5'd1, 21'd0));
`endif
        wait_drain("drain_ts2");
        check("ts_after_2", 64'(timestep), 64'd3);

        // Timesteps 3..9 then wrap
        for (int t = 3; t < 10; t++) empty_timestep(4'(t));
        check("ts_wrap", 64'(timestep), 64'd0);
        empty_timestep(4'd0);
        check("ts_after_wrap", 64'(timestep), 64'd1);

        // Reset in the middle of a drain
        send(pkt_in(2'b11, 5'd4, 5'd4));
        send_dones(6);
        model_map[4] = 21'h000010;
        push_drain(4'd1);
        send(DONE_PKT);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_timestep", 64'(timestep), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);

        // Post-reset timestep: map must have been cleared by reset
        send(pkt_in(2'b11, 5'd2, 5'd1));
        send_dones(6);
        model_map[2] = 21'h000002;
        push_drain(4'd0);
        send(DONE_PKT);
        wait_drain("drain_postrst");
        check("ts_postrst", 64'(timestep), 64'd1);

        // Single spike at column 0
        send(pkt_in(2'b11, 5'd5, 5'd0));
        send_dones(6);
        model_map[5] = 21'h000001;
        push_drain(4'd1);
        send(DONE_PKT);
        wait_drain("drain_single");
        check("ts_final", 64'(timestep), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_map_collector.md
# spike_map_collector

Clocked collector sitting directly downstream of the partial-sum adder stage. It receives output-spike and done packets from all adders, accumulates one 21x21 output spike map per timestep, and, once every adder has signalled done, drains the map row by row as packets toward memory. It then clears the map and advances the timestep.

## Interface
- `MY_ADDR`, 4'b1010: node address; only packets with dest == `MY_ADDR` are accepted.
- `MEM_ADDR`, 4'b0000: destination address of drained packets.
- `NUM_ADDERS`, 7: done packets required to close a timestep.
- `MAP_X`, 21: map rows (x index).
- `MAP_Y`, 21: map columns (y index).
- `NUM_TIMESTEPS`, 10: timestep counter modulus.
- `WIDTH`, 64: packet width.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1: input packet valid.
- `in_ready`  out  1: collector can accept.
- `in_data`  in  WIDTH: packet {dest[63:60], src[59:56], type[55:54], zeros[53:10], x[9:5], y[4:0]}.
- `out_valid`  out  1: drain packet valid.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  WIDTH: drain packet, format under Operation.
- `timestep`  out  4: current timestep.
- `err`  out  1: sticky malformed-packet flag.

## Operation
- FSM states:
  - `COLLECT`: `in_ready`=1.
  - `DRAIN`: `in_ready`=0; emits row packets.
  - `END`: emits the end-of-timestep packet.
  - `CLEAR`: one cycle; zeroes the map, advances `timestep`.
- Accept happens on `in_valid && in_ready`. Accepted packets are classified:
  - dest != `MY_ADDR` or type != 2'b11: dropped, `err` set.
  - addr[9:0] == 10'h3FF (done): `done_cnt`++.
  - otherwise, spike. If x < `MAP_X` and y < `MAP_Y`, set `map[x][y]`=1. Out-of-range coordinates: dropped, `err` set.
- Duplicate spikes are idempotent (OR).
- When an accepted done makes `done_cnt` == `NUM_ADDERS`:
  - next state is `DRAIN`, `row`=0, `done_cnt`=0.
  - that same cycle's accept is the last accepted packet of the timestep.
- DRAIN packet fields:
  - [63:60]=`MEM_ADDR`, [59:56]=`MY_ADDR`, [55:54]=2'b11.
  - [35:32]=`timestep`, [31:27]=`row`, [20:0]=`map[row]`.
  - all other bits 0.
- DRAIN sequencing: on an `out_valid && out_ready` handshake, `row`++. After row `MAP_X`-1 the FSM goes to `END`.
- END packet: same header and timestep as DRAIN; [31:27]=5'h1F, [20:0]=0. Its handshake moves the FSM to `CLEAR`.
- CLEAR:
  - `timestep` = (`timestep`+1) mod `NUM_TIMESTEPS`.
  - returns to `COLLECT`.
- `err` clears only on reset.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `timestep`=0, `err`=0, map zero, state `COLLECT`. `in_ready` rises on the first clock after reset release.
- `in_ready` is registered. It drops the cycle after the closing done is accepted.
- First `out_valid` appears 1 cycle after the closing done.
- `out_valid`/`out_data` are registered and held stable until `out_ready`. The next row is presented in the cycle after the handshake.
- Full drain with `out_ready` tied high takes `MAP_X`+1 cycles (22), plus 1 `CLEAR` cycle. `in_ready` returns 1 cycle after the END handshake plus the `CLEAR` cycle.
- Timestep wrap: 9 -> 0 with default parameters.
- Reset asserted mid-drain aborts the drain immediately. The map, counters and timestep are cleared and no partial END is sent.

## Configuration
- `SPIKE_SKIP_EMPTY_ROWS_EN`
  - Defined: DRAIN emits only rows with nonzero `map[row]`. Row scanning advances one row per cycle when the row is empty, with no `out_valid`. END is always sent.
  - Undefined: all `MAP_X` rows are sent, including empty ones.

## Structure
- `snn_pkg` holds:
  - packet field positions
  - `OUT_SPIKE_TYPE`=2'b11
  - `DONE_ADDR`=10'h3FF
  - `END_ROW`=5'h1F
  - FSM state enum `collector_state_t`
  - the drain-packet assembly function
- Sub-module `spike_packet_decode`: combinational classification into {is_spike, is_done, is_bad, x, y}. The collector instantiates it once.

## Test plan
- Spikes (3,7), (3,7) duplicate, (20,20), then 7 dones -> 21 row packets: row 3 data 21'h000080, row 20 data 21'h100000, others 0. END row 5'h1F, timestep field 0. `timestep` becomes 1.
- Packet type 2'b10, and spike at x=21 -> both dropped, `err`=1, map unchanged. Following done count is unaffected.
- `out_ready` held low 5 cycles on row 0 -> `out_valid` and `out_data` stable throughout. Row 1 is presented the cycle after the handshake.
- Ten full timesteps -> END packets carry timesteps 0..9. After the tenth, `timestep` reads 0.
- `rst_n` pulsed low during row 10 of the drain -> outputs return to reset values, map empty. The next timestep's drain starts at row 0 with timestep 0.
- With `SPIKE_SKIP_EMPTY_ROWS_EN`: only spike (5,0), then 7 dones -> exactly one row packet (row 5, data 21'h000001) followed by END.
